if_fetch_unit: RTL



---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_next_pc.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, fetch
// exception cause codes and the fetch state machine encoding.
package if_fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NopInst = 32'h0000_0013;

  localparam logic [3:0] CauseMisaligned  = 4'd0;
  localparam logic [3:0] CauseAccessFault = 4'd1;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Fetch address selection: priority mux (trap > redirect > sequential) plus
// misalignment and optional ROM range checking. Purely combinational.
// Build option: IFU_RANGE_CHECK_EN enables the out-of-ROM access fault.
module if_next_pc
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned IROM_DEPTH = 10
) (
  input  logic [1:0]  state,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        issue_en,
  output logic [31:0] issue_adr,
  output logic        load,
  output logic        fault,
  output logic [3:0]  cause
);

  localparam logic [32:0] SpanBytes = 33'd4 << IROM_DEPTH;

  logic misaligned;
  logic out_of_range;
  logic range_fault;

  // Pick the address this cycle would fetch and whether the response regs reload.
  always_comb begin
    issue_adr  = pc;
    load       = 1'b0;
    misaligned = 1'b0;
    if (trap_valid) begin
      issue_adr = {trap_pc[31:2], 2'b00};
      load      = 1'b1;
    end else if (redirect_valid && (state != StFault)) begin
      issue_adr  = redirect_pc;
      load       = 1'b1;
      misaligned = |redirect_pc[1:0];
    end else if (!stall && (state == StRun)) begin
      load = 1'b1;
    end
  end

  assign out_of_range = {1'b0, issue_adr} >= SpanBytes;

`ifdef IFU_RANGE_CHECK_EN
  assign range_fault = out_of_range;
`else
  // ROM aliases high address bits; the comparison is simply not used.
  logic unused_out_of_range;
  assign unused_out_of_range = out_of_range;
  assign range_fault = 1'b0;
`endif

  // Misalignment takes precedence over the range fault for the reported cause.
  assign fault    = load && (misaligned || range_fault);
  assign cause    = (!misaligned && range_fault) ? CauseAccessFault : CauseMisaligned;
  assign issue_en = load && !fault;

  logic unused_trap_lsb;
  assign unused_trap_lsb = ^trap_pc[1:0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one ROM read per cycle and
// pairs the ROM's one-cycle-late data with its PC for decode. Handles stall,
// branch redirect, trap redirect and fetch exceptions.
// Build option: IFU_RANGE_CHECK_EN faults fetches beyond the ROM span.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IROM_DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        irom_en,
  output logic [31:0] irom_adr,
  input  logic [31:0] irom_inst,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_exc,
  output logic [3:0]  id_cause
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  resp_pc_q;
  logic         resp_v_q;
  logic         exc_q;
  logic [3:0]   cause_q;

  logic         issue_en;
  logic [31:0]  issue_adr;
  logic         load;
  logic         fault;
  logic [3:0]   cause;

  if_next_pc #(
    .IROM_DEPTH(IROM_DEPTH)
  ) u_next_pc (
    .state         (state_q),
    .pc            (pc_q),
    .stall         (stall_i),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .issue_en      (issue_en),
    .issue_adr     (issue_adr),
    .load          (load),
    .fault         (fault),
    .cause         (cause)
  );

  // Fetch FSM and response registers; the response tracks the address issued last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      resp_v_q  <= 1'b0;
      exc_q     <= 1'b0;
      cause_q   <= CauseMisaligned;
    end else if (load) begin
      resp_v_q  <= 1'b1;
      resp_pc_q <= issue_adr;
      exc_q     <= fault;
      cause_q   <= cause;
      if (fault) begin
        state_q <= StFault;
      end else begin
        state_q <= StRun;
        pc_q    <= issue_adr + 32'd4;
      end
    end else begin
      case (state_q)
        StBoot:  state_q <= StRun;
        // Exception bundle leaves once decode takes it.
        StFault: if (!stall_i) resp_v_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // ROM request is combinational so redirects fetch their target in the same cycle.
  always_comb begin
    irom_en  = !rst && issue_en;
    irom_adr = rst ? RESET_PC : issue_adr;
  end

  // Decode bundle; ROM data only meaningful for a valid, non-faulting response.
  always_comb begin
    id_valid = resp_v_q;
    id_pc    = resp_pc_q;
    id_exc   = exc_q;
    id_cause = cause_q;
    id_inst  = (resp_v_q && !exc_q) ? irom_inst : NopInst;
  end

endmodule
